// File: rtl/pwm_deadtime.sv
// Half-bridge gate driver with programmable dead time, fault latch and
// switching-event counter. The incoming PWM is registered once and every
// decision is made on that registered copy.
module pwm_deadtime #(
  parameter int unsigned DT_W  = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_in,
  input  logic [DT_W-1:0]  dead_cycles,
  input  logic             fault_in,
  input  logic             fault_clr,
  output logic             out_hi,
  output logic             out_lo,
  output logic             fault_latched,
  output logic [CNT_W-1:0] sw_count
);

  localparam logic [2:0] S_OFF   = 3'd0;
  localparam logic [2:0] S_DT_H  = 3'd1;
  localparam logic [2:0] S_HI    = 3'd2;
  localparam logic [2:0] S_DT_L  = 3'd3;
  localparam logic [2:0] S_LO    = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic            pwm_q;
  logic [DT_W-1:0] dead_cnt;
  logic [DT_W-1:0] dead_cnt_nxt;
  logic [DT_W-1:0] dead_len;
  logic            in_dead;
  logic            nxt_dead;

  // Zero dead time still yields one both-off cycle.
  assign dead_len = (dead_cycles == '0) ? DT_W'(1) : dead_cycles;
  assign in_dead  = (state == S_DT_H) || (state == S_DT_L);
  assign nxt_dead = (state_nxt == S_DT_H) || (state_nxt == S_DT_L);

  // Next-state logic: fault beats enable, enable beats normal switching.
  always_comb begin
    state_nxt = state;
    if (fault_in) begin
      state_nxt = S_FAULT;
    end else begin
      case (state)
        S_OFF: begin
          if (en) state_nxt = pwm_q ? S_DT_H : S_DT_L;
        end
        S_DT_H, S_DT_L: begin
          if (!en)                      state_nxt = S_OFF;
          else if (dead_cnt <= DT_W'(1)) state_nxt = pwm_q ? S_HI : S_LO;
        end
        S_HI: begin
          if (!en)        state_nxt = S_OFF;
          else if (!pwm_q) state_nxt = S_DT_L;
        end
        S_LO: begin
          if (!en)       state_nxt = S_OFF;
          else if (pwm_q) state_nxt = S_DT_H;
        end
        S_FAULT: begin
          if (fault_clr) state_nxt = S_OFF;
        end
        default: state_nxt = S_OFF;
      endcase
    end
  end

  // Dead counter: load on entry to a dead state, count down while inside.
  always_comb begin
    dead_cnt_nxt = '0;
    if (nxt_dead) begin
      if (in_dead) dead_cnt_nxt = dead_cnt - DT_W'(1);
      else         dead_cnt_nxt = dead_len;
    end
  end

  // State, input sample and dead counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_OFF;
      pwm_q    <= 1'b0;
      dead_cnt <= '0;
    end else begin
      state    <= state_nxt;
      pwm_q    <= pwm_in;
      dead_cnt <= dead_cnt_nxt;
    end
  end

  // Outputs decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_hi        <= 1'b0;
      out_lo        <= 1'b0;
      fault_latched <= 1'b0;
      sw_count      <= '0;
    end else begin
      out_hi        <= (state_nxt == S_HI);
      out_lo        <= (state_nxt == S_LO);
      fault_latched <= (state_nxt == S_FAULT);
      if ((state_nxt == S_HI) && (state != S_HI)) begin
        sw_count <= sw_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Bench for pwm_deadtime: directed scenarios plus randomized traffic, all
// compared each cycle against a rail/remaining-dead-time reference model.
module tb_pwm_deadtime;

  localparam int unsigned DT_W  = 16;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             pwm_in;
  logic [DT_W-1:0]  dead_cycles;
  logic             fault_in;
  logic             fault_clr;
  logic             out_hi;
  logic             out_lo;
  logic             fault_latched;
  logic [CNT_W-1:0] sw_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: which rail is driven (0 none, 1 high, 2 low),
  // remaining dead cycles, fault flag, switch count.
  bit m_pq;
  bit m_fault;
  int m_rail;
  int m_dead;
  int m_sw;

  pwm_deadtime #(.DT_W(DT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .pwm_in(pwm_in), .dead_cycles(dead_cycles),
    .fault_in(fault_in), .fault_clr(fault_clr), .out_hi(out_hi), .out_lo(out_lo),
    .fault_latched(fault_latched), .sw_count(sw_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs present before the edge.
  task automatic model_edge();
    bit old_pq;
    int d;
    old_pq = m_pq;
    d = (dead_cycles == '0) ? 1 : int'(dead_cycles);
    if (rst) begin
      m_pq = 0; m_fault = 0; m_rail = 0; m_dead = 0; m_sw = 0;
    end else begin
      m_pq = pwm_in;
      if (fault_in) begin
        m_fault = 1; m_rail = 0; m_dead = 0;
      end else if (m_fault) begin
        if (fault_clr) m_fault = 0;
      end else if (!en) begin
        m_rail = 0; m_dead = 0;
      end else if (m_dead > 0) begin
        m_dead--;
        if (m_dead == 0) begin
          m_rail = old_pq ? 1 : 2;
          if (old_pq) m_sw = (m_sw + 1) % (1 << CNT_W);
        end
      end else if (m_rail == 0 || (m_rail == 1 && !old_pq) || (m_rail == 2 && old_pq)) begin
        m_rail = 0; m_dead = d;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("out_hi", 32'(out_hi), 32'(m_rail == 1));
    check("out_lo", 32'(out_lo), 32'(m_rail == 2));
    check("fault_latched", 32'(fault_latched), 32'(m_fault));
    check("sw_count", 32'(sw_count), 32'(m_sw));
    check("hi_lo_exclusive", 32'(out_hi & out_lo), 32'd0);
  endtask

  task automatic wait_both_off();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (!out_hi && !out_lo) begin ok = 1; break; end
      step();
    end
    check("wait_both_off", 32'(ok), 32'd1);
  endtask

  task automatic wait_rail(input bit hi);
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (hi ? out_hi : out_lo) begin ok = 1; break; end
      step();
    end
    check(hi ? "wait_hi" : "wait_lo", 32'(ok), 32'd1);
  endtask

  // Precondition: the current sample is both-off and already counted in gap.
  task automatic count_off(inout int gap);
    for (int i = 0; i < 200; i++) begin
      step();
      if (!out_hi && !out_lo) gap++;
      else break;
    end
  endtask

  initial begin
    int gap;
    rst = 1; en = 0; pwm_in = 0; fault_in = 0; fault_clr = 0; dead_cycles = '0;
    m_pq = 0; m_fault = 0; m_rail = 0; m_dead = 0; m_sw = 0;
    @(negedge clk);
    step(); step();
    check("rst_out_hi", 32'(out_hi), 32'd0);
    check("rst_out_lo", 32'(out_lo), 32'd0);
    check("rst_sw", 32'(sw_count), 32'd0);
    rst = 0;

    // Low-to-high with five cycles of dead time.
    en = 1; dead_cycles = 16'd5;
    wait_rail(0);
    check("sw_before", 32'(sw_count), 32'd0);
    pwm_in = 1;
    wait_both_off();
    gap = 1;
    count_off(gap);
    check("gap_dt5", 32'(gap), 32'd5);
    check("hi_after_dt5", 32'(out_hi), 32'd1);
    check("sw_after", 32'(sw_count), 32'd1);

    // Zero dead time still gives exactly one both-off cycle.
    dead_cycles = '0;
    for (int k = 0; k < 6; k++) begin
      repeat (20) step();
      pwm_in = ~pwm_in;
      wait_both_off();
      gap = 1;
      count_off(gap);
      check("gap_dt0", 32'(gap), 32'd1);
    end

    // Input reversal and dead_cycles change mid-interval.
    pwm_in = 0;
    wait_rail(0);
    dead_cycles = 16'd8; pwm_in = 1;
    wait_both_off();
    gap = 1;
    repeat (2) begin step(); gap++; end
    pwm_in = 0; dead_cycles = 16'd2;
    count_off(gap);
    check("gap_captured", 32'(gap), 32'd8);
    check("lo_after_reversal", 32'(out_lo), 32'd1);

    // Fault latch, clear blocked while fault present, then clean restart.
    pwm_in = 1;
    wait_rail(1);
    fault_in = 1; step(); fault_in = 0;
    check("fault_set", 32'(fault_latched), 32'd1);
    check("fault_hi_off", 32'(out_hi), 32'd0);
    fault_clr = 1; fault_in = 1; step();
    check("fault_held", 32'(fault_latched), 32'd1);
    fault_in = 0; step(); fault_clr = 0;
    check("fault_cleared", 32'(fault_latched), 32'd0);
    dead_cycles = 16'd3;
    step();
    check("restart_dead_hi", 32'(out_hi), 32'd0);
    check("restart_dead_lo", 32'(out_lo), 32'd0);
    wait_rail(1);

    // Counter wrap after 2^CNT_W high entries.
    rst = 1; step(); rst = 0;
    pwm_in = 0; dead_cycles = 16'd1;
    for (int k = 0; k < 16; k++) begin
      pwm_in = 1; wait_rail(1);
      check("sw_inc", 32'(sw_count), 32'((k + 1) % 16));
      pwm_in = 0; wait_rail(0);
    end

    // Reset in the middle of a dead interval.
    dead_cycles = 16'd6; pwm_in = 1;
    wait_both_off();
    step();
    rst = 1; step(); rst = 0;
    check("rst_mid_hi", 32'(out_hi), 32'd0);
    check("rst_mid_lo", 32'(out_lo), 32'd0);
    check("rst_mid_fault", 32'(fault_latched), 32'd0);
    check("rst_mid_sw", 32'(sw_count), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      fault_in  = ($urandom_range(0, 59) == 0);
      fault_clr = ($urandom_range(0, 3) == 0);
      en        = ($urandom_range(0, 29) != 0);
      if ($urandom_range(0, 7) == 0) pwm_in = ~pwm_in;
      if ($urandom_range(0, 9) == 0) dead_cycles = DT_W'($urandom_range(0, 6));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_deadtime.md
PWM_DEADTIME -- requirements
Module: pwm_deadtime

Interface
REQ-001 Parameter DT_W, 16, width of dead-time count input.
REQ-002 Parameter CNT_W, 16, width of switching-event counter.
REQ-003 clk  input  1  system clock; all logic SHALL be clocked on rising edge of clk only.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 en  input  1  bridge enable; 0 forces both gates off.
REQ-006 pwm_in  input  1  raw PWM from upstream PWM generator (setPWM-style output), synchronous to clk.
REQ-007 dead_cycles  input  DT_W  dead time in clk cycles.
REQ-008 fault_in  input  1  external over-current/over-voltage flag, active-high.
REQ-009 fault_clr  input  1  clears latched fault.
REQ-010 out_hi  output  1  high-side gate drive.
REQ-011 out_lo  output  1  low-side gate drive.
REQ-012 fault_latched  output  1  high while in FAULT state.
REQ-013 sw_count  output  CNT_W  number of entries into HI state.

Function
REQ-014 pwm_in SHALL be registered once into pwm_q; all decisions use pwm_q.
REQ-015 FSM states SHALL be OFF, DT_H, HI, DT_L, LO, FAULT.
REQ-016 Outputs SHALL be registered decodes of state: out_hi=1 only in HI, out_lo=1 only in LO; out_hi and out_lo SHALL never be 1 in the same cycle.
REQ-017 OFF: if en=1 and pwm_q=1 -> DT_H; if en=1 and pwm_q=0 -> DT_L; else stay.
REQ-018 LO: pwm_q=1 -> DT_H. HI: pwm_q=0 -> DT_L.
REQ-019 On entry to DT_H/DT_L, dead_cycles SHALL be captured; later changes SHALL not affect the current dead interval.
REQ-020 Dead interval length SHALL be exactly max(dead_cycles,1) cycles with both outputs 0.
REQ-021 At end of dead interval: pwm_q=1 -> HI, pwm_q=0 -> LO, regardless of which dead state (a glitch reversing pwm_q ends in the opposite rail, still after full dead time).
REQ-022 Latency: pwm_q changes at edge N -> active output deasserts at edge N+1 -> opposite output asserts at edge N+1+max(D,1).
REQ-023 en=0 in any non-FAULT state -> OFF at next edge; re-enable SHALL always pass through a dead state.
REQ-024 fault_in=1 at any edge SHALL force FAULT at next edge, priority over en and all transitions.
REQ-025 FAULT exits to OFF only when fault_clr=1 and fault_in=0 on the same edge; fault_clr with fault_in=1 SHALL keep FAULT.
REQ-026 sw_count SHALL increment by 1 on each transition into HI, wrapping from 2^CNT_W-1 to 0.

Reset
REQ-027 rst=1 SHALL, at next edge, set state OFF, pwm_q=0, dead counter 0, out_hi=0, out_lo=0, fault_latched=0, sw_count=0; rst overrides fault_in and mid-dead operation.

Verification
REQ-028 en=1, dead_cycles=5, pwm_in low->high toggle -> out_lo falls, exactly 5 cycles both 0, out_hi rises; sw_count 0->1.
REQ-029 dead_cycles=0, pwm_in toggling every 20 cycles -> exactly 1 both-off cycle at every transition; assertion out_hi&out_lo never true.
REQ-030 In DT_H with dead_cycles=8, pwm_in drops after 3 cycles and dead_cycles changed to 2 -> still 8 both-off cycles, then LO.
REQ-031 fault_in pulse 1 cycle while HI -> next edge both 0, fault_latched=1; fault_clr with fault_in=1 -> stays; fault_clr with fault_in=0 -> OFF, then dead state before any output.
REQ-032 sw_count preloaded by forcing 2^CNT_W-1 transitions (CNT_W=4 build) -> wraps to 0; rst asserted mid-dead -> all outputs 0, sw_count=0 next edge.
